rom_arbiter: RTL and testbench

ROM_ARBITER -- requirements
Module: rom_arbiter

---
 rtl/rom_arbiter.sv | 77 +++++++
 tb/tb_rom_arbiter.sv | 139 +++++++++++++
 2 files changed

// File: rtl/rom_arbiter.sv
// rom_arbiter: two-requester fair arbiter in front of an asynchronous-read ROM.
// One read in flight at a time; ties go to the requester that was not served last.
module rom_arbiter #(
  parameter int ADDRESS_WIDTH = 32,
  parameter int DATA_WIDTH    = 32,
  parameter int DEPTH         = 64
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     req0_valid,
  input  logic [ADDRESS_WIDTH-1:0] req0_addr,
  input  logic                     req1_valid,
  input  logic [ADDRESS_WIDTH-1:0] req1_addr,
  output logic                     req0_ready,
  output logic                     req1_ready,
  output logic                     rsp0_valid,
  output logic                     rsp1_valid,
  input  logic                     rsp0_ready,
  input  logic                     rsp1_ready,
  output logic [DATA_WIDTH-1:0]    rsp_data,
  output logic                     rsp_err,
  output logic [ADDRESS_WIDTH-1:0] rom_addr,
  input  logic [DATA_WIDTH-1:0]    rom_data,
  output logic                     busy
);
  typedef enum logic [1:0] {IDLE, READ, RESP} state_t;
  state_t                   r_state, w_next;
  logic [ADDRESS_WIDTH-1:0] r_rom_addr;
  logic [DATA_WIDTH-1:0]    r_rsp_data;
  logic                     r_rsp_err, r_grant, r_last_grant;
  logic                     w_accept, w_pick, w_hs, w_oor;
  // On a tie the winner is whoever was not granted last time.
  assign w_pick     = (req0_valid && req1_valid) ? ~r_last_grant : req1_valid;
  assign w_accept   = (r_state == IDLE) && (req0_valid || req1_valid);
  assign w_hs       = (r_state == RESP) && (r_grant ? rsp1_ready : rsp0_ready);
  assign w_oor      = r_rom_addr >= ADDRESS_WIDTH'(DEPTH);
  assign req0_ready = w_accept && !w_pick;
  assign req1_ready = w_accept && w_pick;
  assign rsp0_valid = (r_state == RESP) && !r_grant;
  assign rsp1_valid = (r_state == RESP) && r_grant;
  assign rsp_data   = r_rsp_data;
  assign rsp_err    = r_rsp_err;
  assign rom_addr   = r_rom_addr;
  assign busy       = r_state != IDLE;
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    w_next = w_accept ? READ : IDLE;
      READ:    w_next = RESP;
      RESP:    w_next = w_hs ? IDLE : RESP;
      default: w_next = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rom_addr   <= '0;
      r_rsp_data   <= '0;
      r_rsp_err    <= 1'b0;
      r_grant      <= 1'b0;
      r_last_grant <= 1'b1;
    end else begin
      if (w_accept) begin
        r_rom_addr <= w_pick ? req1_addr : req0_addr;
        r_grant    <= w_pick;
      end
      if (r_state == READ) begin
        r_rsp_data <= w_oor ? '0 : rom_data;
        r_rsp_err  <= w_oor;
      end
      if (w_hs) r_last_grant <= r_grant;
    end
  end
endmodule

// File: tb/tb_rom_arbiter.sv
// tb_rom_arbiter: randomized scoreboard bench for rom_arbiter against a transaction-level model.
module tb_rom_arbiter;
  logic        clk = 0, rst = 1;
  logic        req0_valid = 0, req1_valid = 0, rsp0_ready = 0, rsp1_ready = 0;
  logic [31:0] req0_addr = 0, req1_addr = 0, rom_data, rsp_data, rom_addr;
  logic        req0_ready, req1_ready, rsp0_valid, rsp1_valid, rsp_err, busy;
  logic [31:0] rom [64];
  typedef struct {bit id; logic [31:0] d; bit e;} exp_t;
  exp_t q[$];
  int   checks = 0, failures = 0;
  bit   m_last = 1;

  rom_arbiter #(.ADDRESS_WIDTH(32), .DATA_WIDTH(32), .DEPTH(64)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_addr(req0_addr),
    .req1_valid(req1_valid), .req1_addr(req1_addr),
    .req0_ready(req0_ready), .req1_ready(req1_ready),
    .rsp0_valid(rsp0_valid), .rsp1_valid(rsp1_valid),
    .rsp0_ready(rsp0_ready), .rsp1_ready(rsp1_ready),
    .rsp_data(rsp_data), .rsp_err(rsp_err),
    .rom_addr(rom_addr), .rom_data(rom_data), .busy(busy));

  always #5 clk = ~clk;
  assign rom_data = (rom_addr < 64) ? rom[rom_addr[5:0]] : 32'hBAD0_BAD0;

  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    checks++;
    if (a !== e) begin
      failures++;
      $display("FAIL %s got=%h want=%h t=%0t", n, a, e, $time);
    end
  endtask

  always @(negedge clk) if (!rst && (rsp0_valid || rsp1_valid)) begin
    chk("rsp_both_valid", 32'(rsp0_valid & rsp1_valid), 0);
    if (q.size() == 0) chk("rsp_unexpected", {30'b0, rsp1_valid, rsp0_valid}, 0);
    else begin
      chk("rsp_id", 32'(rsp1_valid), 32'(q[0].id));
      chk("rsp_data", rsp_data, q[0].d);
      chk("rsp_err", 32'(rsp_err), 32'(q[0].e));
      if (q[0].id ? rsp1_ready : rsp0_ready) void'(q.pop_front());
    end
  end

  // Called at posedge+1 with the DUT idle; returns at posedge+1 with the DUT idle again.
  task automatic xact(input bit v0, input bit v1, input logic [31:0] a0, input logic [31:0] a1, input int bp);
    bit   w;
    exp_t e;
    w = (v0 && v1) ? !m_last : v1;
    req0_valid = v0; req1_valid = v1; req0_addr = a0; req1_addr = a1;
    rsp0_ready = 1'($urandom); rsp1_ready = 1'($urandom);
    @(negedge clk);
    chk("idle_busy", 32'(busy), 0);
    chk("req0_ready", 32'(req0_ready), 32'(!w));
    chk("req1_ready", 32'(req1_ready), 32'(w));
    e.id = w;
    e.e  = (w ? a1 : a0) >= 64;
    e.d  = e.e ? 32'h0 : rom[(w ? a1[5:0] : a0[5:0])];
    q.push_back(e);
    m_last = w;
    @(posedge clk); #1;
    if (w) begin req1_valid = 0; req1_addr = $urandom; end
    else   begin req0_valid = 0; req0_addr = $urandom; end
    @(negedge clk);
    chk("read_busy", 32'(busy), 1);
    chk("read_rsp_valid", {30'b0, rsp1_valid, rsp0_valid}, 0);
    chk("read_req_ready", {30'b0, req1_ready, req0_ready}, 0);
    @(posedge clk); #1;
    for (int n = 0; n <= bp; n++) begin
      rsp0_ready = w ? 1'b1 : (n >= bp);
      rsp1_ready = w ? (n >= bp) : 1'b1;
      @(negedge clk);
      chk("resp_valid", {30'b0, rsp1_valid, rsp0_valid}, w ? 2 : 1);
      chk("resp_req_ready", {30'b0, req1_ready, req0_ready}, 0);
      @(posedge clk); #1;
    end
    req0_valid = 0; req1_valid = 0;
  endtask

  initial begin
    foreach (rom[i]) rom[i] = $urandom;
    #12;
    chk("rst_rom_addr", rom_addr, 0);
    chk("rst_rsp_data", rsp_data, 0);
    chk("rst_outs", {26'b0, busy, rsp_err, req0_ready, req1_ready, rsp0_valid, rsp1_valid}, 0);
    @(posedge clk); #1 rst = 0;
    req0_valid = 0; req1_valid = 0;
    repeat (2) begin
      @(negedge clk);
      chk("idle_quiet", {28'b0, busy, req1_ready, req0_ready, rsp0_valid | rsp1_valid}, 0);
      @(posedge clk); #1;
    end
    xact(1, 0, 1, 0, 0);
    repeat (4) xact(1, 1, 2, 3, 0);
    xact(1, 1, 7, 9, 0);
    xact(1, 1, 10, 11, 5);
    xact(1, 0, 64, 0, 0);
    xact(1, 0, 63, 0, 0);
    xact(0, 1, 0, 32'hFFFF_FFFF, 1);
    for (int i = 0; i < 40; i++) begin
      bit v0, v1;
      v0 = 1'($urandom); v1 = 1'($urandom);
      if (!v0 && !v1) v0 = 1;
      xact(v0, v1, $urandom_range(0, 80), $urandom_range(0, 80), $urandom_range(0, 3));
    end
    // abort a transaction while it is waiting in RESP
    req0_valid = 1; req0_addr = 5; rsp0_ready = 0; rsp1_ready = 0;
    q.push_back('{id: 0, d: rom[5], e: 0});
    @(posedge clk); #1 req0_valid = 0;
    @(posedge clk); #1;
    @(negedge clk);
    chk("abort_pre_valid", 32'(rsp0_valid), 1);
    @(posedge clk); #1 rst = 1;
    #1;
    chk("abort_outs", {26'b0, busy, rsp_err, req0_ready, req1_ready, rsp0_valid, rsp1_valid}, 0);
    chk("abort_rsp_data", rsp_data, 0);
    chk("abort_rom_addr", rom_addr, 0);
    q.delete();
    m_last = 1;
    @(posedge clk); #1 rst = 0; rsp0_ready = 1; rsp1_ready = 1;
    repeat (3) begin
      @(negedge clk);
      chk("post_abort_quiet", {29'b0, busy, rsp1_valid, rsp0_valid}, 0);
      @(posedge clk); #1;
    end
    xact(1, 1, 20, 21, 0);
    xact(1, 1, 22, 23, 0);
    repeat (2) @(posedge clk);
    chk("scoreboard_drain", q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end
endmodule
